parity_frame_rx: RTL and testbench
==================================

# parity_frame_rx

Serial frame receiver that consumes the bit stream from the even-parity transmit path and checks it. It captures a start bit, DATA_W data bits (LSB first), one parity bit and one stop bit, then presents the parallel word. It sits directly downstream of the even-parity generator. It flags a parity mismatch against that generator's rule: the parity bit is 1 iff the data holds an even number of ones, i.e. P = XNOR-reduce of the data. It also flags a framing error.

## Interface
- DATA_W, 3, data bits per frame (≥2)
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- bit_en  input  1  bit-time strobe; rx is sampled only on cycles with bit_en=1
- rx  input  1  serial line, idle high
- data_out  output  DATA_W  last received word, held until next frame completes
- valid  output  1  one-cycle pulse: frame complete, data_out/par_err/frame_err updated
- par_err  output  1  received parity ≠ ~^data_out; held with data_out
- frame_err  output  1  stop bit sampled as 0; held with data_out
- busy  output  1  frame in progress (states other than IDLE)

## Operation
- FSM states: IDLE, DATA, PARITY, STOP; encoding from shared package.
- IDLE: on bit_en with rx=0 → DATA, bit counter=0. rx=1 or bit_en=0 → stay.
- DATA: each bit_en shifts rx into the shift register at bit position cnt (LSB first) and increments cnt. On the bit_en with cnt=DATA_W-1 → PARITY.
- PARITY: on bit_en, latch rx as p_rx → STOP.
- STOP: on bit_en, registers update on the same edge and the FSM returns to IDLE:
  - data_out←shift reg
  - par_err←(p_rx ≠ ~^shift reg)
  - frame_err←~rx
  - valid←1
- The frame is always delivered; errors are reported through flags only, and data is never dropped.
- No glitch filter on rx: a single start sample commits to a frame.
- Counter width $clog2(DATA_W); the counter never wraps past DATA_W-1.
- A start bit may be accepted on the first bit_en after the STOP sample. There are no idle bit-times between back-to-back frames.

## Timing
- Reset values (async, rst_n=0):
  - state=IDLE, cnt=0, shift reg=0
  - data_out=0, valid=0, par_err=0, frame_err=0, busy=0
- Reset mid-frame: the partial frame is discarded, valid does not pulse, and data_out is cleared to 0.
- valid is high for exactly one clk cycle, the cycle after the edge that sampled the stop bit. It is registered, not combinational from rx.
- Frame latency: DATA_W+3 bit_en strobes from the start sample to the stop sample, then valid on the next cycle.
- busy rises the cycle after the start sample and falls the cycle valid rises.
- bit_en gaps of any length inside a frame only stall the FSM; no timeout.
- bit_en may be held high continuously (one bit per clk).
- rx changes on cycles with bit_en=0 have no effect.

## Configuration
- PARITY_RX_STICKY_ERR_EN defined:
  - adds input clr_err (1 bit) and output err_sticky (1 bit).
  - err_sticky is set on the valid cycle if par_err or frame_err is set, and stays set across subsequent clean frames.
  - clr_err=1 clears err_sticky at the next edge. If a set and a clear occur in the same cycle, the set wins.
  - err_sticky resets to 0.
- Undefined: neither port exists and behaviour is otherwise identical.

## Structure
- Shared package parity_pkg holds:
  - FSM state encodings (2-bit)
  - the default DATA_W
  - the idle-level and stop-level constants (1'b1).
- One sub-module: even_parity_calc (DATA_W-wide XNOR-reduce). It computes the expected parity bit and is reused by the transmit side.

## Test plan
- Reset with DATA_W=3 → all outputs 0, busy=0.
- Send the bit sequence 0,1,0,1,1,1 (start, data 101 LSB first, P=1, stop), bit_en every cycle → data_out=3'b101, valid one cycle, par_err=0, frame_err=0.
- Same frame with P=0 → data_out=3'b101, par_err=1. Next frame 000 with P=1, stop=1 → par_err=0.
- Frame 110, P=1, stop=0 → frame_err=1, par_err=0, valid pulses, FSM back in IDLE.
- Assert rst_n=0 after two data bits, release, then send a clean frame 011 (P=1) → no valid before the clean frame, then data_out=3'b011.
- bit_en every 4th cycle with rx toggling between strobes, plus back-to-back frames → correct words, one valid per frame. With PARITY_RX_STICKY_ERR_EN: err_sticky stays set after a bad frame followed by a good frame, and clears only on clr_err.

Source files
------------

// File: rtl/parity_pkg.sv
// parity_pkg: shared FSM encoding, default word width and line-level constants for the parity frame path
package parity_pkg;
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;
    localparam int   DATA_W_DEF = 3;
    localparam logic IDLE_LVL   = 1'b1;
    localparam logic STOP_LVL   = 1'b1;
endpackage

// File: rtl/even_parity_calc.sv
// even_parity_calc: parity bit that is 1 iff data_i holds an even number of ones
// Ports: data_i [W-1:0] word in; par_o expected parity bit out.
module even_parity_calc #(
    parameter int W = 3
) (
    input  logic [W-1:0] data_i,
    output logic         par_o
);
    assign par_o = ~^data_i;
endmodule

// File: rtl/parity_frame_rx.sv
// parity_frame_rx: receives start/DATA_W data (LSB first)/parity/stop frames and flags parity and framing errors
// Ports: clk, rst_n (async active-low), bit_en (bit strobe), rx (serial in, idle high);
//        data_out (last word), valid (one-cycle frame-done pulse), par_err, frame_err, busy.
// Optional PARITY_RX_STICKY_ERR_EN: adds clr_err input and err_sticky output.
module parity_frame_rx
    import parity_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              bit_en,
    input  logic              rx,
`ifdef PARITY_RX_STICKY_ERR_EN
    input  logic              clr_err,
    output logic              err_sticky,
`endif
    output logic [DATA_W-1:0] data_out,
    output logic              valid,
    output logic              par_err,
    output logic              frame_err,
    output logic              busy
);
    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DATA_W - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0]  shift_q, shift_d;
    logic               p_rx_q, p_rx_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic               valid_q, valid_d;
    logic               par_err_q, par_err_d;
    logic               frame_err_q, frame_err_d;
    logic               par_exp;

    even_parity_calc #(.W(DATA_W)) u_par (
        .data_i (shift_q),
        .par_o  (par_exp)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            shift_q     <= '0;
            p_rx_q      <= 1'b0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            par_err_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            p_rx_q      <= p_rx_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            par_err_q   <= par_err_d;
            frame_err_q <= frame_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        p_rx_d      = p_rx_q;
        data_d      = data_q;
        valid_d     = 1'b0;
        par_err_d   = par_err_q;
        frame_err_d = frame_err_q;
        if (bit_en) begin
            case (state_q)
                IDLE: if (rx != IDLE_LVL) begin
                    state_d = DATA;
                    cnt_d   = '0;
                end
                DATA: begin
                    shift_d[cnt_q] = rx;
                    // Counter parks at its last value instead of wrapping; the next start reloads it.
                    cnt_d   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
                    state_d = (cnt_q == CNT_MAX) ? PARITY : DATA;
                end
                PARITY: begin
                    p_rx_d  = rx;
                    state_d = STOP;
                end
                STOP: begin
                    data_d      = shift_q;
                    par_err_d   = p_rx_q != par_exp;
                    frame_err_d = rx != STOP_LVL;
                    valid_d     = 1'b1;
                    state_d     = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

`ifdef PARITY_RX_STICKY_ERR_EN
    logic sticky_q, sticky_d;
    // A new error in the same cycle as a clear wins over the clear.
    assign sticky_d = (valid_d & (par_err_d | frame_err_d)) | (sticky_q & ~clr_err);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sticky_q <= 1'b0;
        else        sticky_q <= sticky_d;
    end
    assign err_sticky = sticky_q;
`endif

    assign data_out  = data_q;
    assign valid     = valid_q;
    assign par_err   = par_err_q;
    assign frame_err = frame_err_q;
    assign busy      = state_q != IDLE;
endmodule

// File: tb/tb_parity_frame_rx.sv
// tb_parity_frame_rx: directed frames against a frame-level model of the receiver outputs
module tb_parity_frame_rx;
    localparam int DW = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          bit_en = 1'b0;
    logic          rx = 1'b1;
    logic [DW-1:0] data_out;
    logic          valid, par_err, frame_err, busy;
`ifdef PARITY_RX_STICKY_ERR_EN
    logic          clr_err = 1'b0;
    logic          err_sticky;
    logic          exp_sticky = 1'b0;
`endif

    int total = 0;
    int bad = 0;
    int frames_sent = 0;
    int valids_seen = 0;
    bit run = 1'b0;

    logic [DW-1:0] exp_data = '0;
    logic          exp_valid = 1'b0, exp_perr = 1'b0, exp_ferr = 1'b0, exp_busy = 1'b0;

    parity_frame_rx #(.DATA_W(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bit_en    (bit_en),
        .rx        (rx),
`ifdef PARITY_RX_STICKY_ERR_EN
        .clr_err   (clr_err),
        .err_sticky(err_sticky),
`endif
        .data_out  (data_out),
        .valid     (valid),
        .par_err   (par_err),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", n, a, e, $time);
        end
    endtask

    always @(negedge clk) if (run) begin
        chk("valid", 32'(valid), 32'(exp_valid));
        chk("busy", 32'(busy), 32'(exp_busy));
        chk("data_out", 32'(data_out), 32'(exp_data));
        chk("par_err", 32'(par_err), 32'(exp_perr));
        chk("frame_err", 32'(frame_err), 32'(exp_ferr));
`ifdef PARITY_RX_STICKY_ERR_EN
        chk("err_sticky", 32'(err_sticky), 32'(exp_sticky));
`endif
        if (valid) valids_seen++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
        exp_valid = 1'b0;
    endtask

    // Sends start, d (LSB first), parity p, stop s; each bit is one strobe followed by gap-1 idle
    // cycles during which rx toggles without effect.
    task automatic send_frame(input logic [DW-1:0] d, input logic p, input logic s, input int gap);
        logic [DW+2:0] bits;
        bits = {s, p, d, 1'b0};
        for (int i = 0; i < DW + 3; i++) begin
            rx = bits[i];
            bit_en = 1'b1;
            tick();
            bit_en = 1'b0;
            if (i == 0) exp_busy = 1'b1;
            if (i == DW + 2) begin
                exp_valid = 1'b1;
                exp_busy  = 1'b0;
                exp_data  = d;
                exp_perr  = p != ($countones(d) % 2 == 0);
                exp_ferr  = !s;
`ifdef PARITY_RX_STICKY_ERR_EN
                if (exp_perr || exp_ferr) exp_sticky = 1'b1;
`endif
                frames_sent++;
            end
            for (int g = 1; g < gap; g++) begin
                rx = ~rx;
                tick();
            end
        end
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #1 run = 1'b1;
        tick();
        tick();
        chk("rst_data", 32'(data_out), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_valid", 32'(valid), 32'h0);
        rst_n = 1'b1;
        tick();

        send_frame(3'b101, 1'b1, 1'b1, 1);
        chk("f1_data", 32'(data_out), 32'h5);
        chk("f1_valid", 32'(valid), 32'h1);
        chk("f1_perr", 32'(par_err), 32'h0);
        chk("f1_ferr", 32'(frame_err), 32'h0);
        rx = 1'b1;
        tick();
        chk("f1_valid_drop", 32'(valid), 32'h0);

        send_frame(3'b101, 1'b0, 1'b1, 1);
        chk("f2_perr", 32'(par_err), 32'h1);
        chk("f2_data", 32'(data_out), 32'h5);
        send_frame(3'b000, 1'b1, 1'b1, 1);
        chk("f3_perr", 32'(par_err), 32'h0);
        chk("f3_data", 32'(data_out), 32'h0);

        send_frame(3'b110, 1'b1, 1'b0, 1);
        chk("f4_ferr", 32'(frame_err), 32'h1);
        chk("f4_perr", 32'(par_err), 32'h0);
        chk("f4_busy", 32'(busy), 32'h0);
        rx = 1'b1;
        tick();

        rx = 1'b0; bit_en = 1'b1; tick(); exp_busy = 1'b1;
        rx = 1'b1; tick();
        rx = 1'b0; tick();
        bit_en = 1'b0;
        rst_n = 1'b0;
        exp_busy = 1'b0; exp_data = '0; exp_perr = 1'b0; exp_ferr = 1'b0;
`ifdef PARITY_RX_STICKY_ERR_EN
        exp_sticky = 1'b0;
`endif
        tick();
        chk("mid_rst_data", 32'(data_out), 32'h0);
        rst_n = 1'b1;
        rx = 1'b1;
        tick();
        send_frame(3'b011, 1'b1, 1'b1, 1);
        chk("f5_data", 32'(data_out), 32'h3);
        chk("f5_perr", 32'(par_err), 32'h0);

        send_frame(3'b010, 1'b0, 1'b1, 4);
        chk("f6_data", 32'(data_out), 32'h2);
        send_frame(3'b111, 1'b0, 1'b1, 4);
        chk("f7_perr", 32'(par_err), 32'h0);
        send_frame(3'b100, 1'b1, 1'b1, 1);
        chk("f8_perr", 32'(par_err), 32'h1);
        send_frame(3'b001, 1'b0, 1'b1, 1);
        chk("f9_data", 32'(data_out), 32'h1);
        chk("f9_perr", 32'(par_err), 32'h0);
        rx = 1'b1;
        tick();

`ifdef PARITY_RX_STICKY_ERR_EN
        send_frame(3'b011, 1'b0, 1'b1, 1);
        send_frame(3'b011, 1'b1, 1'b1, 1);
        rx = 1'b1;
        tick();
        chk("sticky_hold", 32'(err_sticky), 32'h1);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        exp_sticky = 1'b0;
        tick();
        chk("sticky_clr", 32'(err_sticky), 32'h0);
`endif
        tick();
        tick();
        chk("valid_count", 32'(valids_seen), 32'(frames_sent));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
